// File: rtl/ordered_lane_dispatcher.sv
// Steers metadata beats to NB_LANES lanes (LSB / XOR-fold / round-robin) and re-merges responses in acceptance order.
// Latency: 1 cycle from a consumed lane response to out_valid; 1 beat/cycle sustained on both sides.
// Backpressure: in_ready drops on a full order FIFO or a busy target lane; non-head lane responses are held. LANE_DISPATCH_STATS_EN adds counters.
module ordered_lane_dispatcher #(
    parameter int NB_LANES    = 4,
    parameter int DWIDTH      = 64,
    parameter int QID_WIDTH   = 16,
    parameter int QID_LSB     = 0,
    parameter int ORDER_DEPTH = 32,
    localparam int LANE_W     = (NB_LANES > 1) ? $clog2(NB_LANES) : 1,
    localparam int OCC_W      = $clog2(ORDER_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 sel_mode,
    input  logic [DWIDTH-1:0]          in_data,
    input  logic [QID_WIDTH-1:0]       in_qid,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NB_LANES*DWIDTH-1:0] lane_req_data,
    output logic [NB_LANES-1:0]        lane_req_valid,
    input  logic [NB_LANES-1:0]        lane_req_ready,
    input  logic [NB_LANES*DWIDTH-1:0] lane_rsp_data,
    input  logic [NB_LANES-1:0]        lane_rsp_valid,
    output logic [NB_LANES-1:0]        lane_rsp_ready,
    output logic [DWIDTH-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef LANE_DISPATCH_STATS_EN
    output logic [NB_LANES*32-1:0]     lane_accept_cnt,
    output logic [OCC_W-1:0]           occup_watermark,
`endif
    output logic [OCC_W-1:0]           order_occup,
    output logic [31:0]                stall_cnt
);

    localparam int PTR_W  = $clog2(ORDER_DEPTH);
    localparam int NCHUNK = (QID_WIDTH + LANE_W - 1) / LANE_W;
    localparam int PADW   = NCHUNK * LANE_W;

    logic [LANE_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occup_q, occup_d;
    logic [LANE_W-1:0] order_mem_q [ORDER_DEPTH];
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       stall_q, stall_d;

    logic [PADW-1:0]   qid_pad;
    logic [LANE_W-1:0] fold;
    logic [LANE_W-1:0] sel;
    logic [LANE_W-1:0] head;
    logic [DWIDTH-1:0] head_rsp_data;
    logic              full, empty, push, pop, load_en;

    // Lane select; mode 3 falls back to LSB selection.
    always_comb begin
        qid_pad = PADW'(in_qid);
        fold    = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            fold = fold ^ qid_pad[c*LANE_W +: LANE_W];
        end
        case (sel_mode)
            2'd1:    sel = fold;
            2'd2:    sel = rr_q;
            default: sel = in_qid[QID_LSB +: LANE_W];
        endcase
        if (NB_LANES == 1) begin
            sel = '0;
        end
    end

    // Full is taken from the registered count only, so a same-cycle pop never frees a slot for a push.
    always_comb begin
        full           = (occup_q == OCC_W'(ORDER_DEPTH));
        empty          = (occup_q == '0);
        in_ready       = lane_req_ready[sel] & ~full;
        push           = in_valid & in_ready;
        lane_req_data  = {NB_LANES{in_data}};
        lane_req_valid = '0;
        for (int i = 0; i < NB_LANES; i++) begin
            lane_req_valid[i] = in_valid & ~full & (sel == LANE_W'(i));
        end
    end

    always_comb begin
        head           = order_mem_q[rd_ptr_q];
        load_en        = ~out_valid_q | out_ready;
        lane_rsp_ready = '0;
        head_rsp_data  = '0;
        for (int i = 0; i < NB_LANES; i++) begin
            lane_rsp_ready[i] = load_en & ~empty & (head == LANE_W'(i));
            if (head == LANE_W'(i)) begin
                head_rsp_data = lane_rsp_data[i*DWIDTH +: DWIDTH];
            end
        end
        pop = load_en & ~empty & lane_rsp_valid[head];
    end

    always_comb begin
        rr_d        = rr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occup_d     = occup_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        stall_d     = stall_q;
        if (push && sel_mode == 2'd2 && NB_LANES > 1) begin
            rr_d = rr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_data_d  = head_rsp_data;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        case ({push, pop})
            2'b10:   occup_d = occup_q + 1'b1;
            2'b01:   occup_d = occup_q - 1'b1;
            default: occup_d = occup_q;
        endcase
        if (in_valid && !in_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occup_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            rr_q        <= rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occup_q     <= occup_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    // Entries beyond the occupancy are never read, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            order_mem_q[wr_ptr_q] <= sel;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign order_occup = occup_q;
    assign stall_cnt   = stall_q;

`ifdef LANE_DISPATCH_STATS_EN
    logic [31:0]      acc_q [NB_LANES];
    logic [31:0]      acc_d [NB_LANES];
    logic [OCC_W-1:0] wmark_q, wmark_d;

    always_comb begin
        wmark_d = (occup_q > wmark_q) ? occup_q : wmark_q;
        for (int i = 0; i < NB_LANES; i++) begin
            acc_d[i] = acc_q[i];
            if (push && sel == LANE_W'(i) && acc_q[i] != 32'hFFFF_FFFF) begin
                acc_d[i] = acc_q[i] + 1'b1;
            end
            lane_accept_cnt[i*32 +: 32] = acc_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wmark_q <= '0;
            for (int i = 0; i < NB_LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            wmark_q <= wmark_d;
            for (int i = 0; i < NB_LANES; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign occup_watermark = wmark_q;
`endif

endmodule
